// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding instruction-memory request, redirect
// handling with response draining, and a decode-side register with immediate-format select.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc,
   output logic [2:0]  id_imm_sel
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      REQ   = 2'b01,
      WAIT  = 2'b10,
      DRAIN = 2'b11
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        id_valid_q, id_valid_d;
   logic [31:0] id_inst_q, id_inst_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [2:0]  id_imm_sel_q, id_imm_sel_d;
   logic        req_fire_s;
   logic        load_s;
   logic [31:0] redir_pc_s;

   function automatic logic [2:0] decode_imm_sel(input logic [6:0] opcode);
      logic [2:0] sel;
      case (opcode)
         7'b0010011: sel = 3'b000;
         7'b0000011: sel = 3'b001;
         7'b0100011: sel = 3'b010;
         7'b1100111: sel = 3'b011;
         7'b1101111: sel = 3'b100;
         7'b1100011: sel = 3'b110;
         default:    sel = 3'b111;
      endcase
      return sel;
   endfunction

   // Requesting only while the id register will be free keeps a returning response loadable.
   assign imem_req_valid = (state_q == REQ) && (!id_valid_q || id_ready);
   assign imem_req_addr  = pc_q;
   assign req_fire_s     = imem_req_valid && imem_req_ready;
   assign redir_pc_s     = {redirect_pc[31:2], 2'b00};

   // Next-state, pc and response-load decision.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      load_s  = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = REQ;
         end
         REQ: begin
            if (redirect_valid) begin
               pc_d    = redir_pc_s;
               state_d = req_fire_s ? DRAIN : REQ;
            end else if (req_fire_s) begin
               state_d = WAIT;
            end else begin
               state_d = REQ;
            end
         end
         WAIT: begin
            if (imem_resp_valid) begin
               state_d = REQ;
               if (redirect_valid) begin
                  pc_d = redir_pc_s;
               end else begin
                  load_s = 1'b1;
                  pc_d   = pc_q + 32'd4;
               end
            end else if (redirect_valid) begin
               pc_d    = redir_pc_s;
               state_d = DRAIN;
            end else begin
               state_d = WAIT;
            end
         end
         DRAIN: begin
            if (redirect_valid) begin
               pc_d = redir_pc_s;
            end else begin
               pc_d = pc_q;
            end
            state_d = imem_resp_valid ? REQ : DRAIN;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Decode-side register: redirect beats load, load beats the consume handshake.
   always_comb begin
      id_valid_d   = id_valid_q;
      id_inst_d    = id_inst_q;
      id_pc_d      = id_pc_q;
      id_imm_sel_d = id_imm_sel_q;
      if (redirect_valid) begin
         id_valid_d = 1'b0;
      end else if (load_s) begin
         id_valid_d   = 1'b1;
         id_inst_d    = imem_resp_data;
         id_pc_d      = pc_q;
         id_imm_sel_d = decode_imm_sel(imem_resp_data[6:0]);
      end else if (id_valid_q && id_ready) begin
         id_valid_d = 1'b0;
      end else begin
         id_valid_d = id_valid_q;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         id_valid_q   <= 1'b0;
         id_inst_q    <= 32'd0;
         id_pc_q      <= 32'd0;
         id_imm_sel_q <= 3'b111;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         id_valid_q   <= id_valid_d;
         id_inst_q    <= id_inst_d;
         id_pc_q      <= id_pc_d;
         id_imm_sel_q <= id_imm_sel_d;
      end
   end

   assign id_valid   = id_valid_q;
   assign id_inst    = id_inst_q;
   assign id_pc      = id_pc_q;
   assign id_imm_sel = id_imm_sel_q;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, address of first fetch after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 imem_req_valid  output  1  fetch request valid.
REQ-005 imem_req_addr  output  32  fetch address, equal to internal pc register.
REQ-006 imem_req_ready  input  1  memory accepts request; handshake = valid && ready.
REQ-007 imem_resp_valid  input  1  returned instruction valid; never earlier than the cycle after the request handshake.
REQ-008 imem_resp_data  input  32  returned instruction word.
REQ-009 redirect_valid  input  1  jump/branch redirect from later stage.
REQ-010 redirect_pc  input  32  redirect target.
REQ-011 id_valid  output  1  decode-side register holds an instruction.
REQ-012 id_ready  input  1  decode stage accepts; handshake = id_valid && id_ready.
REQ-013 id_inst  output  32  fetched instruction, feeds immediate generator inst input.
REQ-014 id_pc  output  32  address of id_inst.
REQ-015 id_imm_sel  output  3  immediate-format select, feeds immediate generator imm_sel input.

Function
REQ-016 States: IDLE, REQ, WAIT, DRAIN; at most one outstanding request.
REQ-017 IDLE -> REQ unconditionally on the first clock edge after rst deasserts.
REQ-018 imem_req_valid = (state==REQ) && (!id_valid || id_ready); guarantees the output register is empty when the response returns.
REQ-019 REQ: handshake without redirect -> WAIT; redirect without handshake -> pc<=redirect_pc, stay REQ; redirect with handshake -> pc<=redirect_pc, DRAIN.
REQ-020 WAIT: resp_valid without redirect -> load id register, id_valid<=1, pc<=pc+4, REQ.
REQ-021 WAIT: resp_valid with redirect -> discard response, pc<=redirect_pc, REQ.
REQ-022 WAIT: redirect without resp_valid -> pc<=redirect_pc, DRAIN.
REQ-023 DRAIN: resp_valid -> discard, REQ; redirect in DRAIN -> pc<=redirect_pc, stay DRAIN (a coincident resp_valid still moves to REQ).
REQ-024 Any redirect_valid clears id_valid that cycle; redirect has priority over id handshake and response load.
REQ-025 id handshake without load or redirect -> id_valid<=0; id_inst/id_pc/id_imm_sel hold their values until next load.
REQ-026 id_valid && !id_ready -> id register and id_valid hold unchanged.
REQ-027 pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-028 redirect_pc[1:0] ignored; pc[1:0] always 2'b00.
REQ-029 id_imm_sel decoded from imem_resp_data[6:0] at load: 0010011->000, 0000011->001, 0100011->010, 1100111->011, 1101111->100, 1100011->110, any other opcode->111.
REQ-030 Fetch-to-id latency: id_valid rises on the edge at which resp_valid is sampled in WAIT; id_pc equals the accepted imem_req_addr.

Reset
REQ-031 rst asserted at any time, including mid-request: state<=IDLE, pc<=RESET_PC, id_valid<=0, id_inst<=0, id_pc<=0, id_imm_sel<=3'b111, imem_req_valid=0.
REQ-032 Responses arriving in IDLE are ignored; the first post-reset request uses addr RESET_PC.

Verification
REQ-033 Release rst, req_ready=1, resp_valid one cycle later with 32'h00500093, id_ready=1 -> id_valid=1, id_inst=32'h00500093, id_pc=0, id_imm_sel=000; next request addr=4.
REQ-034 id_ready=0 with id register full -> imem_req_valid=0 and id outputs stable until id_ready=1; then request for next pc issues.
REQ-035 Redirect to 32'h0000_0100 in WAIT, response one cycle later -> response discarded, id_valid stays 0, next request addr=32'h100.
REQ-036 Opcode sweep 0100011, 1101111, 1100011, 0110011 -> id_imm_sel 010, 100, 110, 111.
REQ-037 Redirect to 32'hFFFF_FFFE, then a response -> request addr 32'hFFFF_FFFC, id_pc=32'hFFFF_FFFC, following request addr 32'h0000_0000.
REQ-038 rst asserted during WAIT, response arrives during reset or IDLE -> ignored, id_valid=0, first request addr=RESET_PC.
